sh_bus_target: RTL and testbench

- Parametrised external-bus target for the SH7604 bus. Replaces the fixed RAM and register stub used around the CPU in simulation and small FPGA builds.
- Decodes a memory window and a register window, inserts programmable wait states via WAIT_N and honours byte-lane writes.
- Adds two register-driven sources for exercising the CPU's DMAC and interrupt controller: a DREQ0 pulse-train generator and an IRL level source.

---
 rtl/sh_bus_target_pkg.sv | 40 ++++
 rtl/sh_bus_target_dreq.sv | 81 ++++++++
 rtl/sh_bus_target.sv | 217 +++++++++++++++++++++
 tb/tb_sh_bus_target.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/sh_bus_target_pkg.sv
// Shared types and register map for the SH7604 external-bus target.
// Imported by the bus target top and the DREQ pulse-train generator.
package sh_bus_target_pkg;

  typedef enum logic [1:0] {
    REG_MEM,
    REG_REG,
    REG_NONE
  } region_t;

  typedef enum logic [1:0] {
    BS_IDLE,
    BS_WAIT,
    BS_DATA
  } bus_state_t;

  typedef enum logic [1:0] {
    DG_OFF,
    DG_LOW,
    DG_GAP
  } dreq_state_t;

  // Register offsets within the register window, halfword aligned.
  localparam logic [5:0] OFF_ID       = 6'h00;
  localparam logic [5:0] OFF_STATUS   = 6'h02;
  localparam logic [5:0] OFF_DREQ_LEN = 6'h04;
  localparam logic [5:0] OFF_DREQ_CNT = 6'h06;
  localparam logic [5:0] OFF_IRL      = 6'h08;

  // Classify an access from address bits A[26:14].
  function automatic region_t decode_region(input logic [12:0] hi);
    if (hi == 13'd0) begin
      return REG_MEM;
    end else if (hi == 13'd1) begin
      return REG_REG;
    end
    return REG_NONE;
  endfunction

endpackage

// File: rtl/sh_bus_target_dreq.sv
// DREQ0 pulse-train generator: emits `count` low pulses of `len` CE cycles,
// each followed by a one-cycle high gap.
module sh_dreq_gen
  import sh_bus_target_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic [15:0] len,
  output logic [15:0] count,
  output logic        busy,
  output logic        dreq_n
);

  dreq_state_t state;
  logic [15:0] width;
  logic [15:0] eff_len;
  logic [15:0] next_count;

  // A programmed length of zero still produces a one-cycle pulse.
  assign eff_len    = (len == 16'd0) ? 16'd1 : len;
  assign next_count = (count == 16'd0) ? 16'd0 : count - 16'd1;
  assign busy       = (state != DG_OFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DG_OFF;
      count  <= 16'd0;
      width  <= 16'd0;
      dreq_n <= 1'b1;
    end else if (ce) begin
      if (load) begin
        // A count write restarts the train; zero stops it immediately.
        count <= load_value;
        if (load_value != 16'd0) begin
          state  <= DG_LOW;
          width  <= eff_len;
          dreq_n <= 1'b0;
        end else begin
          state  <= DG_OFF;
          dreq_n <= 1'b1;
        end
      end else begin
        case (state)
          DG_OFF: begin
            if (count != 16'd0) begin
              state  <= DG_LOW;
              width  <= eff_len;
              dreq_n <= 1'b0;
            end
          end
          DG_LOW: begin
            if (width <= 16'd1) begin
              state  <= DG_GAP;
              dreq_n <= 1'b1;
            end else begin
              width <= width - 16'd1;
            end
          end
          DG_GAP: begin
            count <= next_count;
            if (next_count != 16'd0) begin
              state  <= DG_LOW;
              width  <= eff_len;
              dreq_n <= 1'b0;
            end else begin
              state <= DG_OFF;
            end
          end
          default: begin
            state  <= DG_OFF;
            dreq_n <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/sh_bus_target.sv
// SH7604 CS0 bus target: memory window, register window, programmable wait
// states, byte-lane writes, plus DREQ0 and IRL stimulus sources.
module sh_bus_target
  import sh_bus_target_pkg::*;
#(
  parameter int          MEM_AW   = 12,
  parameter int          MEM_WAIT = 1,
  parameter int          REG_WAIT = 0,
  parameter int          BUS16    = 1,
  parameter logic [15:0] ID_VALUE = 16'h0200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic [26:0] A,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  input  logic        BS_N,
  input  logic        CS0_N,
  input  logic        RD_WR_N,
  input  logic [3:0]  WE_N,
  output logic        WAIT_N,
  output logic        DREQ0_N,
  output logic [3:0]  IRL_N
);

  localparam int DEPTH = 2 ** MEM_AW;

  bus_state_t  state;
  logic [15:0] cnt;
  logic [13:0] addr_q;
  logic        rd_q;
  logic [3:0]  we_q;
  region_t     region_q;

  logic        start;
  region_t     live_region;
  logic [15:0] wait_cfg;
  logic        do_access;

  logic [13:0] cur_addr;
  logic        cur_rd;
  logic [3:0]  cur_we;
  region_t     cur_region;

  logic [31:0]       mem [DEPTH];
  logic [MEM_AW-1:0] mem_idx;
  logic [31:0]       mem_word;
  logic [15:0]       mem_half;
  logic [5:0]        reg_off;
  logic [15:0]       reg_val;
  logic [31:0]       rd_data;

  logic [3:0]  lane_en;
  logic [15:0] wr_half;
  logic [31:0] wr_data;
  logic        reg_wr;
  logic        dreq_load;

  logic [15:0] dreq_len;
  logic [15:0] irl;
  logic [15:0] dreq_count;
  logic        dreq_busy;
  logic        unused_bits;

  assign start       = CE_R && !BS_N && !CS0_N;
  assign live_region = decode_region(A[26:14]);

  always_comb begin
    wait_cfg = 16'd0;
    case (live_region)
      REG_MEM: wait_cfg = 16'(MEM_WAIT);
      REG_REG: wait_cfg = 16'(REG_WAIT);
      default: wait_cfg = 16'd0;
    endcase
  end

  // The data phase happens on the same CE edge as the BS_N sample when no
  // waits are configured, so the access fields bypass the latches in IDLE.
  assign cur_addr   = (state == BS_IDLE) ? A[13:0]     : addr_q;
  assign cur_rd     = (state == BS_IDLE) ? RD_WR_N     : rd_q;
  assign cur_we     = (state == BS_IDLE) ? WE_N        : we_q;
  assign cur_region = (state == BS_IDLE) ? live_region : region_q;

  assign do_access = (state == BS_IDLE && start && wait_cfg == 16'd0) ||
                     (state == BS_WAIT && CE_R && cnt == 16'd0);

  assign mem_idx  = cur_addr[MEM_AW+1:2];
  assign mem_word = mem[mem_idx];
  assign mem_half = cur_addr[1] ? mem_word[15:0] : mem_word[31:16];
  assign reg_off  = {cur_addr[5:1], 1'b0};

  always_comb begin
    reg_val = 16'h0000;
    case (reg_off)
      OFF_ID:       reg_val = ID_VALUE;
      OFF_STATUS:   reg_val = {14'h0000, DREQ0_N, dreq_busy};
      OFF_DREQ_LEN: reg_val = dreq_len;
      OFF_DREQ_CNT: reg_val = dreq_count;
      OFF_IRL:      reg_val = irl;
      default:      reg_val = 16'h0000;
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    case (cur_region)
      REG_MEM: rd_data = (BUS16 != 0) ? {2{mem_half}} : mem_word;
      REG_REG: rd_data = {2{reg_val}};
      default: rd_data = 32'h0;
    endcase
  end

  // SH is big-endian: A[1]=0 addresses the upper halfword (lanes 3..2).
  always_comb begin
    lane_en = ~cur_we;
    if (BUS16 != 0) begin
      lane_en = cur_addr[1] ? {2'b00, ~cur_we[1:0]} : {~cur_we[3:2], 2'b00};
    end
  end

  assign wr_half = cur_addr[1] ? DI[15:0] : DI[31:16];
  assign wr_data = (BUS16 != 0) ? {2{wr_half}} : DI;

  assign reg_wr    = do_access && !cur_rd && (cur_region == REG_REG) && (lane_en != 4'b0000);
  assign dreq_load = reg_wr && (reg_off == OFF_DREQ_CNT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= BS_IDLE;
      cnt      <= 16'd0;
      addr_q   <= 14'd0;
      rd_q     <= 1'b1;
      we_q     <= 4'hF;
      region_q <= REG_NONE;
      WAIT_N   <= 1'b1;
      DO       <= 32'h0;
    end else begin
      if (do_access && cur_rd) begin
        DO <= rd_data;
      end
      if (CE_R) begin
        case (state)
          BS_IDLE: begin
            if (start) begin
              addr_q   <= A[13:0];
              rd_q     <= RD_WR_N;
              we_q     <= WE_N;
              region_q <= live_region;
              if (wait_cfg != 16'd0) begin
                state  <= BS_WAIT;
                cnt    <= wait_cfg - 16'd1;
                WAIT_N <= 1'b0;
              end else begin
                state <= BS_DATA;
              end
            end
          end
          BS_WAIT: begin
            if (cnt == 16'd0) begin
              state  <= BS_DATA;
              WAIT_N <= 1'b1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          BS_DATA: state <= BS_IDLE;
          default: begin
            state  <= BS_IDLE;
            WAIT_N <= 1'b1;
          end
        endcase
      end
    end
  end

  // Memory is never reset; a reset coinciding with the commit edge drops it.
  always_ff @(posedge CLK) begin
    if (!RST && do_access && !cur_rd && cur_region == REG_MEM) begin
      for (int b = 0; b < 4; b++) begin
        if (lane_en[b]) begin
          mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dreq_len <= 16'd1;
      irl      <= 16'd0;
    end else if (reg_wr) begin
      case (reg_off)
        OFF_DREQ_LEN: dreq_len <= wr_half;
        OFF_IRL:      irl      <= wr_half;
        default:      ;
      endcase
    end
  end

  assign IRL_N = ~irl[3:0];

  sh_dreq_gen u_dreq (
    .clk        (CLK),
    .rst        (RST),
    .ce         (CE_R),
    .load       (dreq_load),
    .load_value (wr_half),
    .len        (dreq_len),
    .count      (dreq_count),
    .busy       (dreq_busy),
    .dreq_n     (DREQ0_N)
  );

  assign unused_bits = cur_addr[0];

endmodule

// File: tb/tb_sh_bus_target.sv
// Directed bench for sh_bus_target: a table of bus transactions plus
// hand-written sequences for the DREQ train, CE gating and mid-access reset.
module tb_sh_bus_target;

  logic        CLK = 1'b0;
  logic        RST;
  logic        CE_R;
  logic [26:0] A;
  logic [31:0] DI;
  logic [31:0] DO;
  logic        BS_N;
  logic        CS0_N;
  logic        RD_WR_N;
  logic [3:0]  WE_N;
  logic        WAIT_N;
  logic        DREQ0_N;
  logic [3:0]  IRL_N;

  int n_compared   = 0;
  int n_mismatched = 0;

  typedef struct {
    string       name;
    logic [26:0] addr;
    logic        rd;
    logic [3:0]  we_n;
    logic [31:0] di;
    logic [31:0] exp_do;
    int          exp_waits;
    logic [3:0]  exp_irl_n;
  } vec_t;

  vec_t vecs[$];

  logic        rec_en = 1'b0;
  logic        rec[$];

  logic [31:0] dout;
  int          waits;
  logic        dreq_s;
  logic [3:0]  irl_s;
  int          idx, l1, h1, l2, tail;

  sh_bus_target #(
    .MEM_AW   (12),
    .MEM_WAIT (2),
    .REG_WAIT (0),
    .BUS16    (1),
    .ID_VALUE (16'h0200)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .CE_R    (CE_R),
    .A       (A),
    .DI      (DI),
    .DO      (DO),
    .BS_N    (BS_N),
    .CS0_N   (CS0_N),
    .RD_WR_N (RD_WR_N),
    .WE_N    (WE_N),
    .WAIT_N  (WAIT_N),
    .DREQ0_N (DREQ0_N),
    .IRL_N   (IRL_N)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (rec_en) rec.push_back(DREQ0_N);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic void add_vec(input string name, input logic [26:0] addr, input logic rd,
                                  input logic [3:0] we_n, input logic [31:0] di,
                                  input logic [31:0] exp_do, input int exp_waits,
                                  input logic [3:0] exp_irl_n);
    vec_t v;
    v.name = name; v.addr = addr; v.rd = rd; v.we_n = we_n; v.di = di;
    v.exp_do = exp_do; v.exp_waits = exp_waits; v.exp_irl_n = exp_irl_n;
    vecs.push_back(v);
  endfunction

  // One complete CPU access; returns data, wait count and levels at the data phase.
  task automatic apply_stimulus(input logic [26:0] addr, input logic rd, input logic [3:0] we_n,
                                input logic [31:0] di, output logic [31:0] d_out,
                                output int n_waits, output logic dreq_at, output logic [3:0] irl_at);
    @(negedge CLK);
    A = addr; RD_WR_N = rd; WE_N = rd ? 4'hF : we_n; DI = di;
    BS_N = 1'b0; CS0_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    BS_N = 1'b1;
    n_waits = 0;
    while (WAIT_N == 1'b0 && n_waits < 40) begin
      n_waits++;
      @(negedge CLK);
    end
    d_out   = DO;
    dreq_at = DREQ0_N;
    irl_at  = IRL_N;
    @(posedge CLK);
    CS0_N = 1'b1;
  endtask

  initial begin
    RST = 1'b1; CE_R = 1'b1; A = '0; DI = '0; BS_N = 1'b1; CS0_N = 1'b1;
    RD_WR_N = 1'b1; WE_N = 4'hF;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    check_output("reset_do", DO, 32'h0);
    check_output("reset_wait_n", {31'h0, WAIT_N}, 32'h1);
    check_output("reset_dreq0_n", {31'h0, DREQ0_N}, 32'h1);
    check_output("reset_irl_n", {28'h0, IRL_N}, 32'hF);

    add_vec("id_read",       27'h0004000, 1'b1, 4'hF,    32'h0,        32'h02000200, 0, 4'hF);
    add_vec("wr_w0_hi",      27'h0000000, 1'b0, 4'b0011, 32'h12341234, 32'h0,        2, 4'hF);
    add_vec("wr_beef",       27'h0000002, 1'b0, 4'b1100, 32'hBEEFBEEF, 32'h0,        2, 4'hF);
    add_vec("rd_beef",       27'h0000002, 1'b1, 4'hF,    32'h0,        32'hBEEFBEEF, 2, 4'hF);
    add_vec("rd_w0_hi",      27'h0000000, 1'b1, 4'hF,    32'h0,        32'h12341234, 2, 4'hF);
    add_vec("wr_w1_hi",      27'h0000004, 1'b0, 4'b0011, 32'h55665566, 32'h0,        2, 4'hF);
    add_vec("wr_w1_lo",      27'h0000006, 1'b0, 4'b1100, 32'h77887788, 32'h0,        2, 4'hF);
    add_vec("wr_w1_byte3",   27'h0000004, 1'b0, 4'b0111, 32'hABCDABCD, 32'h0,        2, 4'hF);
    add_vec("wr_w1_offlane", 27'h0000004, 1'b0, 4'b1100, 32'hFFFFFFFF, 32'h0,        2, 4'hF);
    add_vec("rd_w1_hi",      27'h0000004, 1'b1, 4'hF,    32'h0,        32'hAB66AB66, 2, 4'hF);
    add_vec("rd_w1_lo",      27'h0000006, 1'b1, 4'hF,    32'h0,        32'h77887788, 2, 4'hF);
    add_vec("rd_status",     27'h0004002, 1'b1, 4'hF,    32'h0,        32'h00020002, 0, 4'hF);
    add_vec("rd_dreq_len",   27'h0004004, 1'b1, 4'hF,    32'h0,        32'h00010001, 0, 4'hF);
    add_vec("wr_irl",        27'h0004008, 1'b0, 4'b0011, 32'h000A000A, 32'h0,        0, 4'h5);
    add_vec("rd_irl",        27'h0004008, 1'b1, 4'hF,    32'h0,        32'h000A000A, 0, 4'h5);
    add_vec("rd_unmapped",   27'h0100000, 1'b1, 4'hF,    32'h0,        32'h0,        0, 4'h5);
    add_vec("wr_unmapped",   27'h0100000, 1'b0, 4'b0000, 32'h99999999, 32'h0,        0, 4'h5);
    add_vec("rd_w0_after",   27'h0000000, 1'b1, 4'hF,    32'h0,        32'h12341234, 2, 4'h5);
    add_vec("rd_reg_unused", 27'h000400A, 1'b1, 4'hF,    32'h0,        32'h0,        0, 4'h5);
    add_vec("rd_dreq_cnt",   27'h0004006, 1'b1, 4'hF,    32'h0,        32'h0,        0, 4'h5);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].addr, vecs[i].rd, vecs[i].we_n, vecs[i].di, dout, waits, dreq_s, irl_s);
      check_output({vecs[i].name, "_waits"}, 32'(waits), 32'(vecs[i].exp_waits));
      if (vecs[i].rd) check_output({vecs[i].name, "_do"}, dout, vecs[i].exp_do);
      check_output({vecs[i].name, "_irl_n"}, {28'h0, irl_s}, {28'h0, vecs[i].exp_irl_n});
    end

    // A strobe presented while CE_R is low must not start an access.
    @(negedge CLK);
    CE_R = 1'b0; A = 27'h0000000; RD_WR_N = 1'b1; BS_N = 1'b0; CS0_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_output("ce_gate_wait_n", {31'h0, WAIT_N}, 32'h1);
    BS_N = 1'b1; CS0_N = 1'b1; CE_R = 1'b1;
    @(posedge CLK);

    // DREQ train: LEN=3, CNT=2.
    apply_stimulus(27'h0004004, 1'b0, 4'b0011, 32'h00030003, dout, waits, dreq_s, irl_s);
    rec.delete();
    rec_en = 1'b1;
    apply_stimulus(27'h0004006, 1'b0, 4'b1100, 32'h00020002, dout, waits, dreq_s, irl_s);
    repeat (20) @(negedge CLK);
    #1 rec_en = 1'b0;
    idx = 0;
    while (idx < rec.size() && rec[idx] !== 1'b0) idx++;
    l1 = 0; while (idx < rec.size() && rec[idx] === 1'b0) begin l1++; idx++; end
    h1 = 0; while (idx < rec.size() && rec[idx] === 1'b1) begin h1++; idx++; end
    l2 = 0; while (idx < rec.size() && rec[idx] === 1'b0) begin l2++; idx++; end
    tail = 0; while (idx < rec.size() && rec[idx] === 1'b1) begin tail++; idx++; end
    check_output("train_low1", 32'(l1), 32'd3);
    check_output("train_gap", 32'(h1), 32'd1);
    check_output("train_low2", 32'(l2), 32'd3);
    check_output("train_tail_high", {31'h0, (idx == rec.size() && tail >= 3)}, 32'h1);
    apply_stimulus(27'h0004002, 1'b1, 4'hF, 32'h0, dout, waits, dreq_s, irl_s);
    check_output("train_status", dout, 32'h00020002);
    apply_stimulus(27'h0004006, 1'b1, 4'hF, 32'h0, dout, waits, dreq_s, irl_s);
    check_output("train_cnt_done", dout, 32'h0);

    // Abort a running train by writing DREQ_CNT=0.
    apply_stimulus(27'h0004006, 1'b0, 4'b1100, 32'h00050005, dout, waits, dreq_s, irl_s);
    apply_stimulus(27'h0004002, 1'b1, 4'hF, 32'h0, dout, waits, dreq_s, irl_s);
    check_output("abort_pre_busy", {31'h0, dout[0]}, 32'h1);
    check_output("abort_pre_low", {31'h0, dreq_s}, 32'h0);
    apply_stimulus(27'h0004006, 1'b0, 4'b1100, 32'h00000000, dout, waits, dreq_s, irl_s);
    check_output("abort_dreq_high", {31'h0, dreq_s}, 32'h1);
    apply_stimulus(27'h0004002, 1'b1, 4'hF, 32'h0, dout, waits, dreq_s, irl_s);
    check_output("abort_status", dout, 32'h00020002);

    // Reset during the WAIT phase of a memory write, with a long DREQ pulse active.
    apply_stimulus(27'h0004004, 1'b0, 4'b0011, 32'h00140014, dout, waits, dreq_s, irl_s);
    apply_stimulus(27'h0004006, 1'b0, 4'b1100, 32'h00030003, dout, waits, dreq_s, irl_s);
    @(negedge CLK);
    A = 27'h0000000; RD_WR_N = 1'b0; WE_N = 4'b0011; DI = 32'hCAFECAFE;
    BS_N = 1'b0; CS0_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    BS_N = 1'b1;
    check_output("rst_pre_wait_n", {31'h0, WAIT_N}, 32'h0);
    check_output("rst_pre_dreq0_n", {31'h0, DREQ0_N}, 32'h0);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_output("rst_wait_n", {31'h0, WAIT_N}, 32'h1);
    check_output("rst_dreq0_n", {31'h0, DREQ0_N}, 32'h1);
    check_output("rst_irl_n", {28'h0, IRL_N}, 32'hF);
    RST = 1'b0; CS0_N = 1'b1; WE_N = 4'hF; RD_WR_N = 1'b1;
    @(posedge CLK);
    apply_stimulus(27'h0000000, 1'b1, 4'hF, 32'h0, dout, waits, dreq_s, irl_s);
    check_output("rst_word_kept", dout, 32'h12341234);
    check_output("rst_word_waits", 32'(waits), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
